// File: rtl/imem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : imem_arb_pkg                                              |
// | Purpose  : Shared types and default parameters for the instruction-  |
// |            memory port arbiter (fetch read vs. DMA loader write).    |
// | Contents : arb_state_e - arbiter FSM state encoding                  |
// |            DEF_*       - default width / burst / yield settings      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package imem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_FETCH = 2'd0,   // fetch owns the port, DMA request pending check
      ARB_DRAIN = 2'd1,   // idle cycle so the last fetch read can return
      ARB_DMA   = 2'd2,   // DMA owns the port
      ARB_YIELD = 2'd3    // forced fetch window after a maximal burst
   } arb_state_e;

   localparam int DEF_XLEN        = 32;
   localparam int DEF_MAX_BURST   = 8;
   localparam int DEF_FETCH_SLOTS = 2;

endpackage
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : imem_port_arbiter                                         |
// | Purpose  : Shares the single IMEM port between core fetch (read) and |
// |            the DMA loader (write). DMA bursts are capped at          |
// |            MAX_BURST beats, after which fetch gets FETCH_SLOTS       |
// |            cycles before DMA may resume.                             |
// | Ports    : clk_i, rst_i           clock / sync active-high reset     |
// |            fetch_req_i/addr_i     fetch read request                 |
// |            fetch_flush_i          drop the response of this grant    |
// |            fetch_gnt_o/rvalid_o   fetch grant / read data valid      |
// |            dma_req_i/addr_i/      DMA write beat                     |
// |            wdata_i/last_i                                            |
// |            dma_gnt_o              DMA beat accepted                  |
// |            dma_stall_o            freeze IF stage while DMA owns port|
// |            imem_en/we/addr/wdata  IMEM port                          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module imem_port_arbiter
   import imem_arb_pkg::*;
#(
   parameter int XLEN        = DEF_XLEN,
   parameter int MAX_BURST   = DEF_MAX_BURST,
   parameter int FETCH_SLOTS = DEF_FETCH_SLOTS
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            fetch_req_i,
   input  logic [XLEN-1:0] fetch_addr_i,
   input  logic            fetch_flush_i,
   output logic            fetch_gnt_o,
   output logic            fetch_rvalid_o,
   input  logic            dma_req_i,
   input  logic [XLEN-1:0] dma_addr_i,
   input  logic [XLEN-1:0] dma_wdata_i,
   input  logic            dma_last_i,
   output logic            dma_gnt_o,
   output logic            dma_stall_o,
   output logic            imem_en_o,
   output logic            imem_we_o,
   output logic [XLEN-1:0] imem_addr_o,
   output logic [XLEN-1:0] imem_wdata_o
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int SW = $clog2(FETCH_SLOTS + 1);

   localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(FETCH_SLOTS - 1);

   arb_state_e      state;
   logic [BW-1:0]   beat_cnt;
   logic [SW-1:0]   slot_cnt;
   logic            rvalid;
   logic            fetch_gnt;
   logic            dma_gnt;
   logic            stall;

   // Grants and stall are decoded from state; reset masks them so nothing
   // reaches IMEM while rst_i is high, even mid-burst.
   always_comb begin
      fetch_gnt = 1'b0;
      dma_gnt   = 1'b0;
      stall     = 1'b0;
      if (!rst_i) begin
         case (state)
            ARB_FETCH, ARB_YIELD: fetch_gnt = fetch_req_i;
            ARB_DRAIN:            stall     = 1'b1;
            ARB_DMA: begin
               dma_gnt = dma_req_i;
               stall   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign fetch_gnt_o    = fetch_gnt;
   assign dma_gnt_o      = dma_gnt;
   assign dma_stall_o    = stall;
   assign fetch_rvalid_o = rvalid;

   // IMEM mux: the two grants are mutually exclusive by construction.
   assign imem_en_o    = dma_gnt | fetch_gnt;
   assign imem_we_o    = dma_gnt;
   assign imem_addr_o  = dma_gnt   ? dma_addr_i   :
                         fetch_gnt ? fetch_addr_i : '0;
   assign imem_wdata_o = dma_gnt   ? dma_wdata_i  : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ARB_FETCH;
         beat_cnt <= '0;
         slot_cnt <= '0;
         rvalid   <= 1'b0;
      end else begin
         // IMEM has a fixed one-cycle read latency.
         rvalid <= fetch_gnt & ~fetch_flush_i;
         case (state)
            ARB_FETCH: begin
               if (dma_req_i) state <= ARB_DRAIN;
            end
            ARB_DRAIN: begin
               state <= ARB_DMA;
            end
            ARB_DMA: begin
               if (!dma_req_i) begin
                  // Loader aborted the burst.
                  state    <= ARB_FETCH;
                  beat_cnt <= '0;
               end else if (dma_last_i) begin
                  state    <= ARB_FETCH;
                  beat_cnt <= '0;
               end else if (beat_cnt == BEAT_LAST) begin
                  // Burst cap reached with more beats pending: hand the
                  // port back to fetch for a guaranteed window.
                  state    <= ARB_YIELD;
                  beat_cnt <= '0;
               end else begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            ARB_YIELD: begin
               if (slot_cnt == SLOT_LAST) begin
                  slot_cnt <= '0;
                  state    <= dma_req_i ? ARB_DRAIN : ARB_FETCH;
               end else begin
                  slot_cnt <= slot_cnt + 1'b1;
               end
            end
            default: begin
               state <= ARB_FETCH;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
